// File: rtl/wb_writeback.sv
// RV32I register-file write side: ALU / load / PC+4 select with load wait.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_writeback #(
  parameter int XLEN = 32
`ifdef WB_RETIRE_CNT_EN
  , parameter int CNT_W = 64
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_rd_addr,
  input  logic [1:0]      i_wb_sel,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic [XLEN-1:0] i_pc,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_byte_off,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic            i_mem_err,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_val,
  output logic            o_wenable,
  output logic            o_pend_valid,
  output logic [4:0]      o_pend_addr,
  output logic            o_exc
`ifdef WB_RETIRE_CNT_EN
  , output logic [CNT_W-1:0] o_retire_cnt
`endif
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;

  state_t          state_q, state_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_val_q, rd_val_d;
  logic            wen_q, wen_d;
  logic            exc_q, exc_d;
  logic            pend_q, pend_d;
  logic [4:0]      pend_addr_q, pend_addr_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            retire;
  logic            xfer;

  function automatic logic [XLEN-1:0] load_ext(
    input logic [2:0]      f3,
    input logic [1:0]      off,
    input logic [XLEN-1:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    load_ext = {{24{b[7]}}, b};
      3'd4:    load_ext = {24'd0, b};
      3'd1:    load_ext = {{16{h[15]}}, h};
      3'd5:    load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  assign o_ready = (state_q == IDLE);
  assign xfer    = i_valid && o_ready;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_val_d    = rd_val_q;
    wen_d       = 1'b0;
    exc_d       = 1'b0;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    f3_d        = f3_q;
    off_d       = off_q;
    retire      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer && i_wb_sel == SEL_LOAD) begin
          state_d     = WAIT_LOAD;
          pend_d      = 1'b1;
          pend_addr_d = i_rd_addr;
          f3_d        = i_funct3;
          off_d       = i_byte_off;
        end else if (xfer) begin
          retire = 1'b1;
          // x0 and wb_sel=none retire without touching the write port
          if (i_rd_addr != 5'd0 &&
              (i_wb_sel == SEL_ALU || i_wb_sel == SEL_PC4)) begin
            wen_d     = 1'b1;
            rd_addr_d = i_rd_addr;
            rd_val_d  = (i_wb_sel == SEL_ALU) ?
                        i_alu_res : i_pc + 32'd4;
          end
        end
      end
      WAIT_LOAD: begin
        if (i_mem_rvalid) begin
          state_d = IDLE;
          pend_d  = 1'b0;
          if (i_mem_err) begin
            exc_d = 1'b1;
          end else begin
            retire = 1'b1;
            if (pend_addr_q != 5'd0) begin
              wen_d     = 1'b1;
              rd_addr_d = pend_addr_q;
              rd_val_d  = load_ext(f3_q, off_q, i_mem_rdata);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      rd_val_q    <= '0;
      wen_q       <= 1'b0;
      exc_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_val_q    <= rd_val_d;
      wen_q       <= wen_d;
      exc_q       <= exc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign rd_addr      = rd_addr_q;
  assign rd_val       = rd_val_q;
  assign o_wenable    = wen_q;
  assign o_exc        = exc_q;
  assign o_pend_valid = pend_q;
  assign o_pend_addr  = pend_addr_q;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_retire_cnt = cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule
